// File: rtl/fifo_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter sharing the ex_fifo write port.
// Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 560,
    parameter int MAX_BURST = 8
) (
    input  logic                      w_clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ack,
    output logic [$clog2(N_REQ)-1:0]  owner,
    input  logic                      w_full,
    output logic                      w_en,
    output logic [DATA_W-1:0]         w_data
);

    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
    localparam logic [OW:0]   N_WIDE   = (OW + 1)'(N_REQ);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [N_REQ-1:0]    gnt_nxt;
    logic [OW-1:0]       ptr;
    logic [OW-1:0]       ptr_nxt;
    logic [OW-1:0]       owner_nxt;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    logic [OW-1:0]       pick;
    logic                pick_vld;
    logic [OW:0]         idx_sum;
    logic                owner_req;
    logic                xfer;
    logic [DATA_W-1:0]   masked [N_REQ];

    // Scan offsets from the highest down so the lowest offset from ptr wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx_sum  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_sum = {1'b0, ptr} + (OW + 1)'(k);
            if (idx_sum >= N_WIDE) begin
                idx_sum = idx_sum - N_WIDE;
            end
            if (req[idx_sum[OW-1:0]]) begin
                pick     = idx_sum[OW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    assign owner_req = req[owner];
    assign xfer      = owner_req & ~w_full;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_nxt     = ST_GRANT;
                    gnt_nxt       = '0;
                    gnt_nxt[pick] = 1'b1;
                    owner_nxt     = pick;
                    cnt_nxt       = '0;
                end
            end
            ST_GRANT: begin
                if (!owner_req || (xfer && (cnt == CNT_LAST))) begin
                    state_nxt = ST_IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
                    cnt_nxt   = '0;
                end else if (xfer) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            gnt   <= '0;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign ack  = gnt & req & {N_REQ{~w_full}};
    assign w_en = |ack;

    // gnt is one-hot or zero, so an AND-OR mux yields zero when idle.
    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign masked[i] = req_data[i*DATA_W +: DATA_W] & {DATA_W{gnt[i]}};
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_data = w_data | masked[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Scenario and random checks of fifo_wr_arbiter against a word-count model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 560;
    localparam int MAX_BURST = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        req;
    logic [DATA_W-1:0]       data [N_REQ];
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        ack;
    logic [1:0]              owner;
    logic                    w_full;
    logic                    w_en;
    logic [DATA_W-1:0]       w_data;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who holds the grant and how many words it has written.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_words;

    logic [N_REQ-1:0]  e_gnt;
    logic [N_REQ-1:0]  e_ack;
    logic              e_wen;
    logic [1:0]        e_owner;
    logic [DATA_W-1:0] e_wdata;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_REQ; g++) begin : g_pack
        assign req_data[g*DATA_W +: DATA_W] = data[g];
    end

    fifo_wr_arbiter #(
        .N_REQ     (N_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .w_clk    (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .ack      (ack),
        .owner    (owner),
        .w_full   (w_full),
        .w_en     (w_en),
        .w_data   (w_data)
    );

    function automatic logic [DATA_W-1:0] rand_word();
        logic [575:0] t;
        for (int i = 0; i < 18; i++) t[i*32 +: 32] = $urandom;
        return t[DATA_W-1:0];
    endfunction

    task automatic model_expect();
        e_gnt   = '0;
        e_ack   = '0;
        e_wdata = '0;
        if (m_busy) begin
            e_gnt[m_owner] = 1'b1;
            e_wdata        = data[m_owner];
            if (req[m_owner] && !w_full) e_ack[m_owner] = 1'b1;
        end
        e_wen   = |e_ack;
        e_owner = 2'(m_owner);
    endtask

    task automatic model_release();
        m_busy  = 1'b0;
        m_ptr   = (m_owner + 1) % N_REQ;
        m_words = 0;
    endtask

    task automatic model_advance();
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_ptr   = 0;
            m_words = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N_REQ; k++) begin
                int i;
                i = (m_ptr + k) % N_REQ;
                if (req[i]) begin
                    m_busy  = 1'b1;
                    m_owner = i;
                    m_words = 0;
                    break;
                end
            end
        end else if (!req[m_owner]) begin
            model_release();
        end else if (!w_full) begin
            m_words++;
            if (m_words == MAX_BURST) model_release();
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic reset_dut();
        rst_n  = 1'b0;
        req    = '0;
        w_full = 1'b0;
        step();
        rst_n  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        req    = 4'b1111;
        w_full = 1'b0;
        for (int i = 0; i < N_REQ; i++) data[i] = rand_word();
        for (int c = 0; c < 3; c++) begin
            step();
            #2;
            n_checks++;
            if ({gnt, ack, w_en, owner} !== 11'b0)
                $display("FAIL reset_hold cyc=%0d got gnt=%b ack=%b w_en=%b owner=%0d want all zero",
                         c, gnt, ack, w_en, owner);
            else n_pass++;
        end
        rst_n = 1'b1;
        step();
        #2;
        n_checks++;
        if (gnt !== 4'b0001) $display("FAIL reset_first_gnt got=%b want=0001", gnt);
        else n_pass++;
        n_checks++;
        if (w_en !== 1'b1 || w_data !== data[0])
            $display("FAIL reset_first_word got w_en=%b data=%h want w_en=1 data=%h", w_en, w_data, data[0]);
        else n_pass++;
    endtask

    task automatic test_single();
        int   acks  = 0;
        int   first = -1;
        int   last  = -1;
        logic got;
        reset_dut();
        req = 4'b0100;
        for (int i = 0; i < N_REQ; i++) data[i] = rand_word();
        for (int c = 0; c < 8; c++) begin
            #2;
            model_expect();
            n_checks++;
            if ({gnt, ack, w_en, owner} !== {e_gnt, e_ack, e_wen, e_owner})
                $display("FAIL single_ctl cyc=%0d got=%b want=%b", c, {gnt, ack, w_en, owner}, {e_gnt, e_ack, e_wen, e_owner});
            else n_pass++;
            n_checks++;
            if (w_data !== e_wdata) $display("FAIL single_data cyc=%0d got=%h want=%h", c, w_data, e_wdata);
            else n_pass++;
            got = ack[2];
            if (got) begin
                acks++;
                if (first < 0) first = c;
                last = c;
            end
            step();
            if (acks == 3) req = 4'b0000;
            else if (got) data[2] = rand_word();
        end
        n_checks++;
        if (acks !== 3 || (last - first) !== 2)
            $display("FAIL single_burst got acks=%0d span=%0d want acks=3 span=2", acks, last - first);
        else n_pass++;
        n_checks++;
        if (gnt !== 4'b0000 || owner !== 2'd2)
            $display("FAIL single_release got gnt=%b owner=%0d want gnt=0000 owner=2", gnt, owner);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int               order[$];
        int               words[$];
        int               gaps[$];
        int               idle_run = 0;
        int               want_order[5] = '{0, 1, 2, 3, 0};
        logic [N_REQ-1:0] prev_gnt = '0;
        logic [N_REQ-1:0] got;
        reset_dut();
        req = 4'b1111;
        for (int i = 0; i < N_REQ; i++) data[i] = rand_word();
        for (int c = 0; c < 46; c++) begin
            #2;
            model_expect();
            n_checks++;
            if ({gnt, ack, w_en, owner} !== {e_gnt, e_ack, e_wen, e_owner})
                $display("FAIL rr_ctl cyc=%0d got=%b want=%b", c, {gnt, ack, w_en, owner}, {e_gnt, e_ack, e_wen, e_owner});
            else n_pass++;
            n_checks++;
            if (w_data !== e_wdata) $display("FAIL rr_data cyc=%0d got=%h want=%h", c, w_data, e_wdata);
            else n_pass++;
            if (gnt != 0 && prev_gnt == 0) begin
                order.push_back(int'(owner));
                words.push_back(0);
                if (order.size() > 1) gaps.push_back(idle_run);
            end
            if (gnt == 0) idle_run++;
            else idle_run = 0;
            if (w_en && words.size() > 0) words[words.size()-1] = words[words.size()-1] + 1;
            prev_gnt = gnt;
            got      = ack;
            step();
            for (int i = 0; i < N_REQ; i++) if (got[i]) data[i] = rand_word();
        end
        n_checks++;
        if (order.size() != 5) $display("FAIL rr_grants got=%0d want=5", order.size());
        else begin
            n_pass++;
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (order[k] != want_order[k] || words[k] != MAX_BURST)
                    $display("FAIL rr_grant%0d got owner=%0d words=%0d want owner=%0d words=%0d",
                             k, order[k], words[k], want_order[k], MAX_BURST);
                else n_pass++;
            end
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (gaps[k] != 1) $display("FAIL rr_gap%0d got=%0d want=1", k, gaps[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_full_stall();
        int   acks     = 0;
        int   stall    = 0;
        int   done_cyc = -1;
        logic got;
        reset_dut();
        req = 4'b0001;
        data[0] = rand_word();
        for (int c = 0; c < 20; c++) begin
            w_full = (acks == 3 && stall < 5);
            #2;
            model_expect();
            n_checks++;
            if ({gnt, ack, w_en, owner} !== {e_gnt, e_ack, e_wen, e_owner})
                $display("FAIL stall_ctl cyc=%0d got=%b want=%b", c, {gnt, ack, w_en, owner}, {e_gnt, e_ack, e_wen, e_owner});
            else n_pass++;
            if (w_full) begin
                stall++;
                n_checks++;
                if (gnt !== 4'b0001 || w_en !== 1'b0 || ack !== 4'b0000)
                    $display("FAIL stall_hold cyc=%0d got gnt=%b w_en=%b ack=%b want 0001/0/0000", c, gnt, w_en, ack);
                else n_pass++;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                n_checks++;
                if (gnt !== 4'b0000) $display("FAIL stall_release got=%b want=0000", gnt);
                else n_pass++;
            end
            got = ack[0];
            if (got) begin
                acks++;
                if (acks == MAX_BURST) done_cyc = c;
            end
            step();
            if (got) data[0] = rand_word();
        end
        n_checks++;
        if (done_cyc != 13 || stall != 5)
            $display("FAIL stall_burst got last_word_cyc=%0d stall=%0d want 13 and 5", done_cyc, stall);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int   acks = 0;
        logic got;
        reset_dut();
        req = 4'b0010;
        data[1] = rand_word();
        for (int c = 0; c < 20 && acks < 4; c++) begin
            #2;
            model_expect();
            n_checks++;
            if ({gnt, ack, w_en, owner} !== {e_gnt, e_ack, e_wen, e_owner})
                $display("FAIL rstmid_ctl cyc=%0d got=%b want=%b", c, {gnt, ack, w_en, owner}, {e_gnt, e_ack, e_wen, e_owner});
            else n_pass++;
            got = ack[1];
            if (got) acks++;
            step();
            if (got) data[1] = rand_word();
        end
        n_checks++;
        if (acks != 4) $display("FAIL rstmid_words got=%0d want=4 within budget", acks);
        else n_pass++;
        rst_n = 1'b0;
        req   = 4'b0011;
        data[0] = rand_word();
        step();
        rst_n = 1'b1;
        #2;
        n_checks++;
        if (gnt !== 4'b0000 || w_en !== 1'b0 || owner !== 2'd0)
            $display("FAIL rstmid_clear got gnt=%b w_en=%b owner=%0d want 0000/0/0", gnt, w_en, owner);
        else n_pass++;
        step();
        #2;
        n_checks++;
        if (gnt !== 4'b0001 || w_data !== data[0])
            $display("FAIL rstmid_regrant got gnt=%b want 0001 with req0 data", gnt);
        else n_pass++;
    endtask

    task automatic test_drop();
        int               acks0 = 0;
        logic [N_REQ-1:0] seq[$];
        logic [N_REQ-1:0] got;
        reset_dut();
        req = 4'b0011;
        for (int i = 0; i < N_REQ; i++) data[i] = rand_word();
        for (int c = 0; c < 10; c++) begin
            #2;
            model_expect();
            n_checks++;
            if ({gnt, ack, w_en, owner} !== {e_gnt, e_ack, e_wen, e_owner})
                $display("FAIL drop_ctl cyc=%0d got=%b want=%b", c, {gnt, ack, w_en, owner}, {e_gnt, e_ack, e_wen, e_owner});
            else n_pass++;
            seq.push_back(gnt);
            got = ack;
            if (ack[0]) acks0++;
            step();
            if (acks0 == 2) req[0] = 1'b0;
            for (int i = 0; i < N_REQ; i++) if (got[i]) data[i] = rand_word();
        end
        n_checks++;
        if (seq[3] !== 4'b0001 || seq[4] !== 4'b0000 || seq[5] !== 4'b0010)
            $display("FAIL drop_sequence got %b,%b,%b want 0001,0000,0010", seq[3], seq[4], seq[5]);
        else n_pass++;
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            rst_n  = ($urandom_range(0, 63) != 0);
            req    = 4'($urandom);
            w_full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N_REQ; i++) data[i] = rand_word();
            #2;
            model_expect();
            n_checks++;
            if ({gnt, ack, w_en, owner} !== {e_gnt, e_ack, e_wen, e_owner})
                $display("FAIL random_ctl cyc=%0d got=%b want=%b", c, {gnt, ack, w_en, owner}, {e_gnt, e_ack, e_wen, e_owner});
            else n_pass++;
            n_checks++;
            if (w_data !== e_wdata) $display("FAIL random_data cyc=%0d got=%h want=%h", c, w_data, e_wdata);
            else n_pass++;
            step();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_reset_mid();
        test_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
